// File: rtl/bp_me_stream_pump_in.sv
// Inbound stream pump between a BedRock message port and a per-beat FSM.
// Messages can arrive as one beat or as several beats. They are presented to
// the FSM as 1:1, 1:N (one beat fanned out) or N:1 (beats collapsed to one).
// Every output is combinational from the message inputs and fsm_ready_and_i.

package bp_me_stream_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg     = 2'd0,
    e_bp_small_paddr_cfg = 2'd1
  } bp_params_e;

  localparam int dword_width_gp    = 64;
  localparam int cce_block_width_p = 512;

  localparam int bedrock_default_payload_width_gp = 16;
  localparam int bedrock_msg_type_width_gp        = 4;
  localparam int bedrock_subop_width_gp           = 4;
  localparam int bedrock_size_width_gp            = 3;

  function automatic int bp_paddr_width(bp_params_e cfg);
    return (cfg == e_bp_small_paddr_cfg) ? 32 : 40;
  endfunction

  function automatic int bp_lce_id_width(bp_params_e cfg);
    return (cfg == e_bp_small_paddr_cfg) ? 2 : 4;
  endfunction

endpackage

module bp_me_stream_pump_in
  import bp_me_stream_pkg::*;
#(
  parameter bp_params_e bp_params_p       = e_bp_default_cfg,
  parameter int         stream_data_width_p = dword_width_gp,
  parameter int         block_width_p       = cce_block_width_p,
  parameter int         payload_width_p     = bedrock_default_payload_width_gp,
  parameter logic [(1 << bedrock_msg_type_width_gp)-1:0] msg_stream_mask_p = '0,
  parameter logic [(1 << bedrock_msg_type_width_gp)-1:0] fsm_stream_mask_p = msg_stream_mask_p,

  localparam int paddr_width_p  = bp_paddr_width(bp_params_p),
  localparam int lce_id_width_p = bp_lce_id_width(bp_params_p),
  // H: BedRock header width
  localparam int hdr_width_lp = payload_width_p + bedrock_size_width_gp + paddr_width_p
                              + bedrock_subop_width_gp + bedrock_msg_type_width_gp,
  localparam int stream_words_lp = block_width_p / stream_data_width_p,
  // L: beat counter width, at least one bit
  localparam int cnt_width_lp = (stream_words_lp > 1) ? $clog2(stream_words_lp) : 1
) (
  input  logic                           clk_i,
  input  logic                           reset_i,

  input  logic [hdr_width_lp-1:0]        msg_header_i,
  input  logic [stream_data_width_p-1:0] msg_data_i,
  input  logic                           msg_v_i,
  input  logic                           msg_last_i,
  output logic                           msg_ready_and_o,

  output logic [hdr_width_lp-1:0]        fsm_base_header_o,
  output logic [stream_data_width_p-1:0] fsm_data_o,
  output logic                           fsm_v_o,
  input  logic                           fsm_ready_and_i,
  output logic [cnt_width_lp-1:0]        fsm_cnt_o,
  output logic                           fsm_new_o,
  output logic                           fsm_last_o,
  output logic                           fsm_done_o
);

  // S: byte offset bits within one beat; B: byte offset bits within a block
  localparam int stream_offset_width_lp = $clog2(stream_data_width_p / 8);
  localparam int block_offset_width_lp  = $clog2(block_width_p / 8);

  if (block_width_p < stream_data_width_p) begin : g_bad_block_width
    $error("block_width_p must be at least stream_data_width_p");
  end
  if (block_width_p % stream_data_width_p != 0) begin : g_bad_ratio
    $error("block_width_p must be a multiple of stream_data_width_p");
  end
  if (payload_width_p < lce_id_width_p) begin : g_bad_payload
    $error("payload_width_p too narrow to carry an LCE id");
  end

  typedef struct packed {
    logic [payload_width_p-1:0]           payload;
    logic [bedrock_size_width_gp-1:0]     size;
    logic [paddr_width_p-1:0]             addr;
    logic [bedrock_subop_width_gp-1:0]    subop;
    logic [bedrock_msg_type_width_gp-1:0] msg_type;
  } bedrock_hdr_s;

  bedrock_hdr_s msg_hdr, fsm_hdr;

  logic [cnt_width_lp-1:0] num_stream, first_cnt, last_cnt;
  logic [cnt_width_lp-1:0] cnt_r, fsm_cnt, wrap_cnt;
  logic [block_offset_width_lp-1:0] crit_r, crit_addr;
  logic streaming_r;
  logic msg_stream, fsm_stream, n_to_one;
  logic is_last, msg_is_last;
  logic fsm_hs, cnt_adv, done;
  int unsigned size_beats;

  assign msg_hdr           = msg_header_i;
  assign fsm_base_header_o = fsm_hdr;

  // Beats in this message minus one, from the header size field
  always_comb begin
    size_beats = (32'd1 << msg_hdr.size) >> stream_offset_width_lp;
    if (size_beats == 0) size_beats = 1;
    num_stream = cnt_width_lp'(size_beats - 32'd1);
  end

  assign first_cnt = msg_hdr.addr[stream_offset_width_lp +: cnt_width_lp];
  assign last_cnt  = first_cnt + num_stream;
  assign fsm_cnt   = streaming_r ? cnt_r : first_cnt;
  assign crit_addr = streaming_r ? crit_r : msg_hdr.addr[block_offset_width_lp-1:0];

  if (stream_words_lp == 1) begin : g_single
    // One beat fills a block: nothing to count, every message is 1:1.
    assign streaming_r = 1'b0;
    assign cnt_r       = '0;
    assign crit_r      = msg_hdr.addr[block_offset_width_lp-1:0];
    assign msg_stream  = 1'b0;
    assign fsm_stream  = 1'b0;
    assign is_last     = 1'b1;
  end else begin : g_multi
    assign msg_stream = msg_stream_mask_p[msg_hdr.msg_type] & (first_cnt != last_cnt);
    assign fsm_stream = fsm_stream_mask_p[msg_hdr.msg_type] & (first_cnt != last_cnt);
    assign is_last    = (fsm_cnt == last_cnt) | ~(msg_stream | fsm_stream);

    // Beat counter and in-transaction flag; done wins over advance
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        cnt_r       <= '0;
        streaming_r <= 1'b0;
      end else if (done) begin
        cnt_r       <= '0;
        streaming_r <= 1'b0;
      end else if (cnt_adv) begin
        cnt_r       <= fsm_cnt + cnt_width_lp'(1);
        streaming_r <= 1'b1;
      end
    end

    // Critical address latched while idle so N:1 can report it at the end
    // NOTE: pure data register with no reset; it is only read once
    // streaming_r is set, by which time it has been loaded.
    always_ff @(posedge clk_i) begin
      if (!streaming_r) crit_r <= msg_hdr.addr[block_offset_width_lp-1:0];
    end
  end

  assign n_to_one    = msg_stream & ~fsm_stream;
  assign msg_is_last = ~msg_stream | is_last;

  // Wrap-around beat address: counted bits come from the counter
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    wrap_cnt = '0;
    for (int i = 0; i < cnt_width_lp; i++) begin
      wrap_cnt[i] = num_stream[i] ? fsm_cnt[i]
                                  : msg_hdr.addr[stream_offset_width_lp + i];
    end
  end

  // FSM-facing header: per-beat address, or critical address for N:1
  always_comb begin
    fsm_hdr = msg_hdr;
    if (n_to_one) fsm_hdr.addr[block_offset_width_lp-1:0] = crit_addr;
    else          fsm_hdr.addr[stream_offset_width_lp +: cnt_width_lp] = wrap_cnt;
  end

  // Handshake routing for the 1:1, 1:N and N:1 cases
  always_comb begin
    fsm_v_o         = msg_v_i;
    msg_ready_and_o = fsm_ready_and_i;
    fsm_data_o      = msg_data_i;
    case ({msg_stream, fsm_stream})
      2'b01: msg_ready_and_o = fsm_ready_and_i & is_last;
      2'b10: begin
        fsm_v_o         = msg_v_i & is_last;
        msg_ready_and_o = is_last ? fsm_ready_and_i : 1'b1;
      end
      default: ;
    endcase
  end

  assign fsm_hs  = fsm_v_o & fsm_ready_and_i;
  assign done    = fsm_hs & is_last;
  assign cnt_adv = n_to_one ? (msg_v_i & msg_ready_and_o & ~is_last)
                            : (fsm_hs & ~is_last);

  assign fsm_cnt_o  = fsm_cnt;
  assign fsm_new_o  = fsm_hs & ~streaming_r;
  assign fsm_last_o = is_last & fsm_v_o;
  assign fsm_done_o = done;

  // The sender's last flag must agree with the beat count derived here
  assert property (@(posedge clk_i) disable iff (reset_i)
                   msg_last_i == (msg_is_last & msg_v_i));

endmodule

// File: doc/bp_me_stream_pump_in.md
BP_ME_STREAM_PUMP_IN -- requirements
Module: bp_me_stream_pump_in

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- bp_params_p, e_bp_default_cfg, processor configuration providing paddr_width_p and lce_id_width_p.
- stream_data_width_p, dword_width_gp, width of one beat.
- block_width_p, cce_block_width_p, maximum message data size in bits.
- payload_width_p, "inv", width of the BedRock payload.
- msg_stream_mask_p, 0, bitmask of msg_types that arrive as multiple beats on the msg side.
- fsm_stream_mask_p, msg_stream_mask_p, bitmask of msg_types presented as multiple beats to the FSM.

REQ-002 The block SHALL define these derived widths:
- H = BedRock xce header width.
- S = clog2(stream_data_width_p/8).
- B = clog2(block_width_p/8).
- L = clog2(block_width_p/stream_data_width_p), safe minimum 1.

REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk_i, in, 1, the single clock.
- reset_i, in, 1, synchronous active-high reset.
- msg_header_i, in, H, input stream header; constant across all beats of a message.
- msg_data_i, in, stream_data_width_p, input beat data.
- msg_v_i, in, 1, input beat valid.
- msg_last_i, in, 1, marks the final input beat.
- msg_ready_and_o, out, 1, input beat accept.
- fsm_base_header_o, out, H, header with the address adjusted per beat.
- fsm_data_o, out, stream_data_width_p, beat data to the FSM.
- fsm_v_o, out, 1, FSM beat valid.
- fsm_ready_and_i, in, 1, FSM beat accept.
- fsm_cnt_o, out, L, current beat index.
- fsm_new_o, out, 1, first FSM beat handshakes this cycle.
- fsm_last_o, out, 1, current FSM beat is the last.
- fsm_done_o, out, 1, last FSM beat handshakes this cycle.

Function
REQ-004 The block SHALL compute num_stream = max(2^size / (stream_data_width_p/8), 1) - 1, from msg_header_i.size, truncated to L bits.

REQ-005 The block SHALL compute first_cnt = msg_header_i.addr[S +: L] and last_cnt = first_cnt + num_stream, both modulo 2^L.

REQ-006 A message SHALL be treated as msg-stream when msg_stream_mask_p[msg_type] is set and first_cnt != last_cnt, and as fsm-stream under the same rule using fsm_stream_mask_p.

REQ-007 fsm_cnt_o SHALL equal first_cnt on the first beat of a transaction (streaming_r == 0) and the registered counter value otherwise.

REQ-008 The wrap-around address SHALL be formed bitwise, per bit i: bit i of num_stream ? fsm_cnt_o[i] : addr[S+i].

REQ-009 fsm_base_header_o SHALL equal msg_header_i with addr[S +: L] replaced by the wrap-around count, except in the N:1 case (REQ-013).

REQ-010 is_last SHALL be true when fsm_cnt_o == last_cnt, or when the message is neither msg-stream nor fsm-stream; fsm_last_o = is_last & fsm_v_o.

REQ-011 In the 1:1 case (both stream flags or neither):
- fsm_v_o = msg_v_i.
- msg_ready_and_o = fsm_ready_and_i.
- fsm_data_o = msg_data_i.
- The counter advances on each handshake that is not last.

REQ-012 In the 1:N case (fsm-stream only; single msg beat, N FSM beats):
- fsm_v_o = msg_v_i.
- msg_ready_and_o = fsm_ready_and_i & is_last, so the msg beat is held until the last FSM beat.
- Every FSM beat carries the same msg_data_i.

REQ-013 In the N:1 case (msg-stream only):
- msg_ready_and_o = ~is_last, so non-last beats are consumed silently with fsm_v_o = 0.
- The last beat sets fsm_v_o = msg_v_i and msg_ready_and_o = fsm_ready_and_i.
- fsm_base_header_o.addr[0 +: B] SHALL hold the critical address captured on the first beat.

REQ-014 fsm_new_o SHALL equal fsm_v_o & fsm_ready_and_i & ~streaming_r.

REQ-015 fsm_done_o SHALL equal fsm_v_o & fsm_ready_and_i & is_last.

REQ-016 streaming_r SHALL be set by any non-last counter advance and cleared by fsm_done_o; clear SHALL take priority over set.

REQ-017 The counter SHALL load first_cnt+1 on the first advance and SHALL load 0 on fsm_done_o.

REQ-018 The critical-address register SHALL capture msg_header_i.addr[0 +: B] whenever streaming_r == 0 and SHALL bypass that captured value combinationally in the same cycle.

REQ-019 When block_width_p == stream_data_width_p, the block SHALL have no state: is_last = 1, streaming_r = 0, and every message is handled as 1:1.

REQ-020 Latency SHALL be zero cycles: every output path is combinational from the msg inputs and fsm_ready_and_i.

REQ-021 msg_last_i SHALL be used only by an assertion that it equals (the computed is_last on the msg side) & msg_v_i.

Reset
REQ-022 On reset_i, the counter SHALL be 0, streaming_r SHALL be 0, and all handshake and status outputs SHALL follow REQ-011..015 with streaming_r == 0.

REQ-023 A reset_i asserted mid-message SHALL abandon the transaction; the next beat SHALL be treated as the first beat.

REQ-024 Elaboration SHALL fail if block_width_p % stream_data_width_p != 0 or if block_width_p < stream_data_width_p.

Verification
Configuration for all scenarios: stream_data_width_p = 64, block_width_p = 512, unless stated otherwise.
REQ-025 1:1 write, size 64B, addr 0x1010, 8 beats:
- fsm addr[5:3] SHALL run 2,3,4,5,6,7,0,1.
- fsm_new_o SHALL be asserted on beat 0 and fsm_done_o on beat 7.
- The counter SHALL return to 0.

REQ-026 1:1 write, size 32B, addr 0x1018:
- fsm addr[5:3] SHALL run 3,0,1,2, with addr bit 5 unchanged.
- fsm_last_o SHALL be asserted on the 4th beat.

REQ-027 1:N read, fsm-stream only, size 64B, one msg beat:
- The bench SHALL see 8 FSM beats.
- msg_ready_and_o SHALL be asserted only on the 8th FSM beat.

REQ-028 N:1, msg-stream only, 8 msg beats, addr 0x1028:
- 7 beats SHALL be silently acked.
- The FSM SHALL see 1 beat with addr[5:0] = 0x28.

REQ-029 fsm_ready_and_i = 0 for 3 cycles mid-stream:
- Outputs SHALL be held stable and the counter unchanged.
- Asserting reset_i afterwards SHALL make the next beat report fsm_cnt_o = first_cnt.

REQ-030 Size 8B, or a msg_type not in either mask:
- The message SHALL be a single beat.
- fsm_new_o and fsm_done_o SHALL be asserted in the same cycle.
